// File: rtl/lsu_if.sv
// Core-side request/response channel plus the byte-wide RAM port of the load/store unit.
// The slave modport is the lsu's view; the master modport is the core/RAM environment's view.
interface lsu_if #(
   parameter int ADDR_SZ = 8,
   parameter int DATA_SZ = 8
);
   logic                   req_valid;
   logic                   req_ready;
   logic                   req_we;
   logic [1:0]             req_size;
   logic [ADDR_SZ-1:0]     req_addr;
   logic [4*DATA_SZ-1:0]   req_wdata;

   logic                   rsp_valid;
   logic                   rsp_err;
   logic [4*DATA_SZ-1:0]   rsp_rdata;

   logic [ADDR_SZ-1:0]     ram_addr;
   logic [DATA_SZ-1:0]     ram_wdata;
   logic [DATA_SZ-1:0]     ram_rdata;
   logic                   ram_we;

   modport slave (
      input  req_valid, req_we, req_size, req_addr, req_wdata, ram_rdata,
      output req_ready, rsp_valid, rsp_err, rsp_rdata, ram_addr, ram_wdata, ram_we
   );

   modport master (
      output req_valid, req_we, req_size, req_addr, req_wdata, ram_rdata,
      input  req_ready, rsp_valid, rsp_err, rsp_rdata, ram_addr, ram_wdata, ram_we
   );
endinterface

// File: rtl/lsu.sv
// Load/store unit: splits 1/2/4-byte requests into little-endian single-byte RAM
// accesses and returns a one-cycle response with zero-extended load data.
module lsu #(
   parameter int ADDR_SZ = 8,
   parameter int DATA_SZ = 8
) (
   input  logic clk,
   input  logic rst,
   lsu_if.slave bus
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WR      = 3'd1;
   localparam logic [2:0] S_RD      = 3'd2;
   localparam logic [2:0] S_RD_TAIL = 3'd3;
   localparam logic [2:0] S_RSP     = 3'd4;

   logic [2:0]                  state_q, state_d;
   logic [2:0]                  k_q, k_d;
   logic [1:0]                  last_q, last_d;
   logic                        we_q, we_d;
   logic                        err_q, err_d;
   logic [ADDR_SZ-1:0]          addr_q, addr_d;
   logic [3:0][DATA_SZ-1:0]     wdata_q, wdata_d;
   logic [3:0][DATA_SZ-1:0]     rdata_q, rdata_d;

   logic                        rdata_clr;
   logic                        cap_en;
   logic [1:0]                  cap_idx;

   // last_q holds N-1 so the final-byte test is a plain equality on the counter
   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      last_d    = last_q;
      we_d      = we_q;
      err_d     = err_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_clr = 1'b0;
      cap_en    = 1'b0;
      cap_idx   = 2'd0;

      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               we_d    = bus.req_we;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               k_d     = 3'd0;
               case (bus.req_size)
                  2'b00:   last_d = 2'd0;
                  2'b01:   last_d = 2'd1;
                  2'b10:   last_d = 2'd3;
                  default: last_d = 2'd0;
               endcase
               if (!bus.req_we) begin
                  rdata_clr = 1'b1;
               end
               if (bus.req_size == 2'b11) begin
                  err_d   = 1'b1;
                  state_d = S_RSP;
               end else begin
                  err_d   = 1'b0;
                  state_d = bus.req_we ? S_WR : S_RD;
               end
            end
         end
         S_WR: begin
            k_d = k_q + 3'd1;
            if (k_q == {1'b0, last_q}) begin
               state_d = S_RSP;
            end
         end
         S_RD: begin
            // RAM data for the address issued last cycle arrives now
            if (k_q != 3'd0) begin
               cap_en  = 1'b1;
               cap_idx = 2'(k_q - 3'd1);
            end
            k_d = k_q + 3'd1;
            if (k_q == {1'b0, last_q}) begin
               state_d = S_RD_TAIL;
            end
         end
         S_RD_TAIL: begin
            cap_en  = 1'b1;
            cap_idx = last_q;
            state_d = S_RSP;
         end
         S_RSP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_rbyte
         assign rdata_d[gi] = rdata_clr                            ? '0 :
                              (cap_en && (cap_idx == 2'(gi)))      ? bus.ram_rdata :
                                                                     rdata_q[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         k_q     <= 3'd0;
         last_q  <= 2'd0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         last_q  <= last_d;
         we_q    <= we_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   logic in_wr;
   logic in_rd;
   assign in_wr = (state_q == S_WR);
   assign in_rd = (state_q == S_RD);

   // All outputs decode from registered state; req_ready is also held low during reset
   assign bus.req_ready = (state_q == S_IDLE) && !rst;
   assign bus.ram_we    = in_wr;
   assign bus.ram_addr  = (in_wr || in_rd) ? (addr_q + ADDR_SZ'(k_q)) : '0;
   assign bus.ram_wdata = in_wr ? wdata_q[k_q[1:0]] : '0;
   assign bus.rsp_valid = (state_q == S_RSP);
   assign bus.rsp_err   = (state_q == S_RSP) && err_q;
   assign bus.rsp_rdata = rdata_q;

   // we_q is latched for completeness of the request record; direction is encoded in the state
   logic unused_we;
   assign unused_we = we_q;

endmodule

// File: tb/tb_lsu.sv
// Randomized and directed bench for lsu against a byte-array memory model with
// cycle-accurate expectations derived from the request timing rules.
module tb_lsu;

   logic clk;
   logic rst;
   logic ram_clr;

   int vectors;
   int miscompares;

   lsu_if #(.ADDR_SZ(8), .DATA_SZ(8)) bus ();

   lsu #(.ADDR_SZ(8), .DATA_SZ(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Byte-wide RAM with one-cycle synchronous read
   logic [7:0] ram_mem [256];
   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < 256; i++) ram_mem[i] <= 8'h00;
      end else if (bus.ram_we) begin
         ram_mem[bus.ram_addr] <= bus.ram_wdata;
      end
      bus.ram_rdata <= ram_mem[bus.ram_addr];
   end

   // Reference memory: what the RAM must contain after each completed request
   logic [7:0] model_mem [256];

   function automatic int size_bytes(input logic [1:0] size);
      case (size)
         2'b00:   return 1;
         2'b01:   return 2;
         2'b10:   return 4;
         default: return 0;
      endcase
   endfunction

   // Drives one request at a negedge where ready is expected and checks every cycle
   // through the one after the response pulse.
   task automatic run_txn(input logic we, input logic [1:0] size,
                          input logic [7:0] addr, input logic [31:0] wdata);
      int n, lat, waited;
      logic err;
      logic [31:0] exp_rd;
      logic [19:0] obs, exp;
      logic [7:0] a;
      waited = 0;
      while (!bus.req_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      vectors++;
      if (!bus.req_ready) begin
         miscompares++;
         $display("FAIL accept_timeout: req_ready=%0b required 1", bus.req_ready);
         return;
      end
      n   = size_bytes(size);
      err = (size == 2'b11);
      lat = err ? 1 : (we ? n + 1 : n + 2);
      exp_rd = '0;
      for (int i = 0; i < n; i++) begin
         a = addr + 8'(i);
         exp_rd[i*8 +: 8] = model_mem[a];
      end
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_size  = size;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_wdata = $urandom;
      bus.req_addr  = 8'($urandom);
      for (int c = 1; c <= lat + 1; c++) begin
         logic act;
         if (c > 1) @(negedge clk);
         act = !err && (c <= n);
         a   = addr + 8'(c - 1);
         exp = {(c == lat + 1), (we && act), (act ? a : 8'h00),
                ((we && act) ? wdata[(c-1)*8 +: 8] : 8'h00),
                (c == lat), (err && c == lat)};
         obs = {bus.req_ready, bus.ram_we, bus.ram_addr, bus.ram_wdata,
                bus.rsp_valid, bus.rsp_err};
         vectors++;
         if (obs !== exp) begin
            miscompares++;
            $display("FAIL txn_cycle we=%0b size=%0d addr=%02h C%0d: {rdy,we,addr,wd,rv,re}=%05h required %05h",
                     we, size, addr, c, obs, exp);
         end
         if (!we && !err && c >= lat) begin
            vectors++;
            if (bus.rsp_rdata !== exp_rd) begin
               miscompares++;
               $display("FAIL load_rdata addr=%02h size=%0d C%0d: got %08h required %08h",
                        addr, size, c, bus.rsp_rdata, exp_rd);
            end
         end
      end
      if (we && !err) begin
         for (int i = 0; i < n; i++) begin
            a = addr + 8'(i);
            model_mem[a] = wdata[i*8 +: 8];
         end
      end
      $display("txn we=%0b size=%0d addr=%02h wdata=%08h rdata=%08h", we, size, addr, wdata, bus.rsp_rdata);
   endtask

   task automatic test_reset();
      logic [19:0] obs;
      rst = 1'b1;
      ram_clr = 1'b1;
      bus.req_valid = 1'b1;
      repeat (3) @(negedge clk);
      obs = {bus.req_ready, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.rsp_valid, bus.rsp_err};
      vectors++;
      if (obs !== 20'h0 || bus.rsp_rdata !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: outputs=%05h rdata=%08h required 00000 / 00000000", obs, bus.rsp_rdata);
      end
      bus.req_valid = 1'b0;
      rst = 1'b0;
      ram_clr = 1'b0;
      @(negedge clk);
      vectors++;
      if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release: ready=%0b rsp_valid=%0b required 1/0", bus.req_ready, bus.rsp_valid);
      end
      $display("reset checked");
   endtask

   task automatic test_directed();
      run_txn(1'b1, 2'b10, 8'h10, 32'hDDCCBBAA);
      run_txn(1'b0, 2'b10, 8'h10, 32'h0);
      run_txn(1'b0, 2'b00, 8'h12, 32'h0);
      run_txn(1'b1, 2'b01, 8'hFF, 32'h00002211);
      run_txn(1'b0, 2'b01, 8'hFF, 32'h0);
      run_txn(1'b1, 2'b10, 8'hFE, 32'h44332211);
      run_txn(1'b0, 2'b10, 8'hFE, 32'h0);
      run_txn(1'b1, 2'b11, 8'h20, 32'hFFFFFFFF);
      run_txn(1'b0, 2'b11, 8'h21, 32'h0);
      run_txn(1'b0, 2'b00, 8'h13, 32'h0);
   endtask

   task automatic test_back_to_back();
      logic [31:0] w1, w2;
      int waited;
      w1 = $urandom;
      w2 = $urandom;
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_size  = 2'b10;
      bus.req_addr  = 8'h80;
      bus.req_wdata = w1;
      @(posedge clk);
      @(negedge clk);
      bus.req_size  = 2'b01;
      bus.req_addr  = 8'h90;
      bus.req_wdata = w2;
      for (int c = 1; c <= 6; c++) begin
         if (c > 1) @(negedge clk);
         vectors++;
         if (bus.req_ready !== (c == 6) || bus.rsp_valid !== (c == 5)) begin
            miscompares++;
            $display("FAIL b2b_first C%0d: ready=%0b rsp_valid=%0b required %0b/%0b",
                     c, bus.req_ready, bus.rsp_valid, (c == 6), (c == 5));
         end
      end
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      vectors++;
      if (bus.ram_we !== 1'b1 || bus.ram_addr !== 8'h90 || bus.ram_wdata !== w2[7:0]) begin
         miscompares++;
         $display("FAIL b2b_second_start: we=%0b addr=%02h wd=%02h required 1/90/%02h",
                  bus.ram_we, bus.ram_addr, bus.ram_wdata, w2[7:0]);
      end
      waited = 0;
      while (!bus.rsp_valid && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      vectors++;
      if (bus.rsp_valid !== 1'b1 || waited != 2) begin
         miscompares++;
         $display("FAIL b2b_second_rsp: rsp_valid=%0b after %0d cycles required 1 after 2", bus.rsp_valid, waited);
      end
      @(negedge clk);
      for (int i = 0; i < 4; i++) model_mem[8'h80 + 8'(i)] = w1[i*8 +: 8];
      for (int i = 0; i < 2; i++) model_mem[8'h90 + 8'(i)] = w2[i*8 +: 8];
      $display("b2b stores %08h @80, %04h @90", w1, w2[15:0]);
      run_txn(1'b0, 2'b10, 8'h80, 32'h0);
      run_txn(1'b0, 2'b01, 8'h90, 32'h0);
   endtask

   task automatic test_reset_mid();
      logic [31:0] w;
      logic [19:0] obs;
      w = $urandom;
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_size  = 2'b10;
      bus.req_addr  = 8'h40;
      bus.req_wdata = w;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      obs = {bus.req_ready, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.rsp_valid, bus.rsp_err};
      vectors++;
      if (obs !== 20'h0 || bus.rsp_rdata !== 32'h0) begin
         miscompares++;
         $display("FAIL midrst_outputs: outputs=%05h rdata=%08h required 00000 / 00000000", obs, bus.rsp_rdata);
      end
      rst = 1'b0;
      model_mem[8'h40] = w[7:0];
      model_mem[8'h41] = w[15:8];
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         vectors++;
         if (bus.ram_we !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_quiet cycle %0d: we=%0b rsp_valid=%0b ready=%0b required 0/0/1",
                     c, bus.ram_we, bus.rsp_valid, bus.req_ready);
         end
      end
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (ram_mem[8'h40 + 8'(i)] !== model_mem[8'h40 + 8'(i)]) begin
            miscompares++;
            $display("FAIL midrst_mem byte %0d: got %02h required %02h",
                     i, ram_mem[8'h40 + 8'(i)], model_mem[8'h40 + 8'(i)]);
         end
      end
      $display("mid-store reset wdata=%08h", w);
      run_txn(1'b0, 2'b10, 8'h40, 32'h0);
   endtask

   task automatic test_random();
      for (int t = 0; t < 60; t++) begin
         run_txn(1'($urandom), 2'($urandom), 8'($urandom), $urandom);
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst = 1'b1;
      ram_clr = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_size  = 2'b00;
      bus.req_addr  = 8'h00;
      bus.req_wdata = 32'h0;
      for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
      @(negedge clk);
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
